// File: rtl/tcdm_bank_responder.sv
// Single-ported word-wide SRAM bank behind one TCDM crossbar slave port; TCDM_BANK_STALL_EN adds LFSR grant stalls.
// Latency: LATENCY cycles (1..4) from accept edge to rvalid_o; one request accepted per cycle.
// Backpressure: none on responses; requests are held off only through gnt_o when TCDM_BANK_STALL_EN is defined.
module tcdm_bank_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned NUM_WORDS  = 256,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned IDX_W   = $clog2(NUM_WORDS);
    localparam int unsigned IDX_LSB = $clog2(BE_WIDTH) + $clog2(NUM_BANKS);

    typedef struct packed {
        logic                  vld;
        logic [DATA_WIDTH-1:0] dat;
    } rsp_t;

    logic                  accept;
    logic [IDX_W-1:0]      idx;
    logic                  addr_unused;
    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    rsp_t                  pipe_q [LATENCY];
    rsp_t                  pipe_d [LATENCY];

    // Bank-select and byte-offset bits were consumed by the crossbar.
    assign idx         = addr_i[IDX_LSB +: IDX_W];
    assign addr_unused = ^addr_i;
    assign accept      = req_i & gnt_o;

`ifdef TCDM_BANK_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  stall_cnt_q, stall_cnt_d;

    always_comb begin
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        gnt_o       = req_i & (~lfsr_q[0] | (stall_cnt_q == 2'd3));
        stall_cnt_d = 2'd0;
        if (req_i && !gnt_o) begin
            stall_cnt_d = (stall_cnt_q == 2'd3) ? 2'd3 : stall_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            lfsr_q      <= 16'hACE1;
            stall_cnt_q <= 2'd0;
        end else begin
            lfsr_q      <= lfsr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign gnt_o = req_i;
`endif

    // Storage is deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (accept && we_i) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (be_i[k]) begin
                    mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        pipe_d[0].vld = accept;
        pipe_d[0].dat = (accept && !we_i) ? mem_q[idx] : '0;
        for (int s = 1; s < LATENCY; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int s = 0; s < LATENCY; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign rvalid_o = pipe_q[LATENCY-1].vld;
    assign rdata_o  = pipe_q[LATENCY-1].dat;

endmodule
